// File: rtl/dircc_mem_arbiter.sv
// dircc_mem_arbiter
// Round-robin arbiter that shares one pipelined memory port between
// NUM_REQ requesters. Each command passes through a one-cycle IDLE
// (arbitration) phase and a GRANT (issue) phase. A small ID FIFO records
// which requester owns each outstanding read. In-order read returns are
// routed back through that FIFO as a one-hot strobe.

module dircc_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_byteenable,
    output logic [NUM_REQ-1:0]            req_waitrequest,
    output logic [DATA_W-1:0]             req_readdata,
    output logic [NUM_REQ-1:0]            req_readdatavalid,
    output logic [ADDR_W-1:0]             m_address,
    output logic                          m_read,
    output logic                          m_write,
    output logic [DATA_W-1:0]             m_writedata,
    output logic [DATA_W/8-1:0]           m_byteenable,
    input  logic                          m_waitrequest,
    input  logic [DATA_W-1:0]             m_readdata,
    input  logic                          m_readdatavalid,
    output logic [$clog2(MAX_PEND):0]     pend_count,
    output logic [1:0]                    err_sticky
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = $clog2(MAX_PEND) + 1;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Turn a requester index into a one-hot vector across all requesters.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q,  state_d;
    logic [IDX_W-1:0] grant_q,  grant_d;
    logic [IDX_W-1:0] last_q,   last_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]       err_q,    err_d;
    logic [IDX_W-1:0] id_mem_q [MAX_PEND];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]  addr_arr_s [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr_s[NUM_REQ];
    logic [BE_W-1:0]    be_arr_s   [NUM_REQ];

    logic               rd_room_s;
    logic [NUM_REQ-1:0] elig_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [IDX_W-1:0]   cand_s;

    logic               g_write_s;
    logic               g_read_s;
    logic               g_both_s;
    logic               g_active_s;
    logic               accept_s;
    logic               push_s;
    logic               pop_s;
    logic               orphan_s;
    logic [IDX_W-1:0]   head_id_s;

    // Split the flat requester buses into per-requester slices.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr_s[i]  = req_address[i*ADDR_W +: ADDR_W];
            wdata_arr_s[i] = req_writedata[i*DATA_W +: DATA_W];
            be_arr_s[i]    = req_byteenable[i*BE_W +: BE_W];
        end
    end

    // Eligibility and round-robin pick starting just after the last accepted requester.
    always_comb begin
        rd_room_s    = (cnt_q != MAX_CNT);
        elig_s       = req_write | (req_read & {NUM_REQ{rd_room_s}});
        pick_found_s = 1'b0;
        pick_idx_s   = last_q;
        cand_s       = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand_s == LAST_IDX) begin
                cand_s = {IDX_W{1'b0}};
            end else begin
                cand_s = cand_s + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (!pick_found_s && elig_s[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Decode the granted requester's command. Write wins over read. A read
    // is only issued while the ID FIFO has room. This also covers a requester
    // that switches from write to read while its write grant is stalled.
    always_comb begin
        g_write_s  = req_write[grant_q];
        g_both_s   = req_read[grant_q] & req_write[grant_q];
        g_read_s   = req_read[grant_q] & ~req_write[grant_q] & rd_room_s;
        g_active_s = g_write_s | g_read_s;
        accept_s   = (state_q == ST_GRANT) & g_active_s & ~m_waitrequest;
        push_s     = accept_s & g_read_s;
        pop_s      = m_readdatavalid & (cnt_q != ZERO_CNT);
        orphan_s   = m_readdatavalid & (cnt_q == ZERO_CNT);
        head_id_s  = id_mem_q[rd_ptr_q];
    end

    // Drive the shared memory port from the granted slice. The port is quiet in IDLE.
    always_comb begin
        if (state_q == ST_GRANT) begin
            m_address    = addr_arr_s[grant_q];
            m_writedata  = wdata_arr_s[grant_q];
            m_byteenable = be_arr_s[grant_q];
            m_write      = g_write_s;
            m_read       = g_read_s;
        end else begin
            m_address    = {ADDR_W{1'b0}};
            m_writedata  = {DATA_W{1'b0}};
            m_byteenable = {BE_W{1'b0}};
            m_write      = 1'b0;
            m_read       = 1'b0;
        end
    end

    // Requester-side handshake and read-return routing.
    always_comb begin
        if (accept_s) begin
            req_waitrequest = ~idx_to_onehot(grant_q);
        end else begin
            req_waitrequest = {NUM_REQ{1'b1}};
        end
        if (pop_s) begin
            req_readdatavalid = idx_to_onehot(head_id_s);
        end else begin
            req_readdatavalid = {NUM_REQ{1'b0}};
        end
        req_readdata = m_readdata;
        pend_count   = cnt_q;
        err_sticky   = err_q;
    end

    // Arbitration FSM next state: pick in IDLE, then hold, accept or abandon in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_GRANT;
                    grant_d = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!g_active_s) begin
                    // Requester withdrew: abandon without advancing the round-robin pointer.
                    state_d = ST_IDLE;
                end else if (!m_waitrequest) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ID FIFO pointers, occupancy and sticky error flags next state.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | {accept_s & g_both_s, orphan_s};
    end

    // Control and bookkeeping registers with asynchronous reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= {IDX_W{1'b0}};
            last_q   <= LAST_IDX;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // ID FIFO storage: record the owner of each accepted read. Only entries
    // between the pointers are ever read, so the storage needs no reset.
    always_ff @(posedge clk_clk) begin
        if (push_s) begin
            id_mem_q[wr_ptr_q] <= grant_q;
        end
    end

endmodule
